// File: rtl/rom_fetch_pkg.sv
// rom_fetch_pkg: shared state encoding and reader indices for the ROM fetch scheduler
package rom_fetch_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_e;
   localparam logic [1:0] RD_MAIN = 2'd0;
   localparam logic [1:0] RD_SUB  = 2'd1;
   localparam logic [1:0] RD_WAV  = 2'd2;
   function automatic logic [1:0] rr_next(input logic [1:0] i);
      return (i == RD_WAV) ? RD_MAIN : i + 2'd1;
   endfunction
endpackage

// File: rtl/rom_word_cache.sv
// rom_word_cache: one tagged 16-bit word per reader with hit compare
module rom_word_cache #(
   parameter int AW = 23
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          clr,
   input  logic          ld,
   input  logic [AW-1:0] ld_tag,
   input  logic [15:0]   ld_data,
   input  logic [AW-1:0] addr,
   output logic [15:0]   q,
   output logic          ok
);
   logic [AW-1:0] tag_q, tag_d;
   logic [15:0]   word_q, word_d;
   logic          valid_q, valid_d;
   always_comb begin
      valid_d = clr ? 1'b0 : (ld | valid_q);
      tag_d   = ld ? ld_tag : tag_q;
      word_d  = ld ? ld_data : word_q;
   end
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         tag_q   <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         tag_q   <= tag_d;
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end
   assign q  = word_q;
   assign ok = valid_q & (tag_q == addr);
endmodule

// File: rtl/rom_fetch_sched.sv
// rom_fetch_sched: shares one toggle-handshake SDRAM port between ROM download writes and three cached ROM readers
module rom_fetch_sched
   import rom_fetch_pkg::*;
#(
   parameter int            AW       = 23,
   parameter logic [AW-1:0] SUB_BASE = AW'(23'h7000),
   parameter logic [AW-1:0] WAV_BASE = AW'(23'h8000)
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          dl_active,
   input  logic          dl_wr,
   input  logic [23:0]   dl_addr,
   input  logic [7:0]    dl_data,
   input  logic [AW-1:0] rd_addr0,
   input  logic [AW-1:0] rd_addr1,
   input  logic [AW-1:0] rd_addr2,
   output logic [15:0]   rd_q0,
   output logic [15:0]   rd_q1,
   output logic [15:0]   rd_q2,
   output logic          rd_ok0,
   output logic          rd_ok1,
   output logic          rd_ok2,
   output logic          mem_req,
   input  logic          mem_ack,
   output logic          mem_we,
   output logic [AW-1:0] mem_a,
   output logic [1:0]    mem_ds,
   output logic [15:0]   mem_d,
   input  logic [15:0]   mem_q
);
   state_e        state_q, state_d;
   logic          req_q, req_d, we_q, we_d;
   logic [AW-1:0] a_q, a_d;
   logic [1:0]    ds_q, ds_d, sel_q, sel_d, last_q, last_d;
   logic [15:0]   d_q, d_d;
   logic          pend_q, pend_d, ovr_q, ovr_d, dl_wr_q, dl_act_q;
   logic [23:0]   pend_a_q, pend_a_d;
   logic [7:0]    pend_dat_q, pend_dat_d;
   logic [AW-1:0] full_addr [3];
   logic [15:0]   word [3];
   logic [2:0]    ok, pendr;
   logic [1:0]    c0, c1, c2, pick;
   logic          dl_rise, act_rise, done, issue_wr, ld_word;
   assign full_addr[RD_MAIN] = rd_addr0;
   assign full_addr[RD_SUB]  = rd_addr1 + SUB_BASE;
   assign full_addr[RD_WAV]  = rd_addr2 + WAV_BASE;
   always_comb begin
      dl_rise    = dl_wr & ~dl_wr_q;
      act_rise   = dl_active & ~dl_act_q;
      done       = (mem_ack == req_q);
      pendr      = ~ok & {3{~dl_active}};
      c0         = rr_next(last_q);
      c1         = rr_next(c0);
      c2         = rr_next(c1);
      pick       = pendr[c0] ? c0 : pendr[c1] ? c1 : c2;
      issue_wr   = (state_q == IDLE) & pend_q;
      ld_word    = (state_q == WAIT) & done & ~we_q;
      // a fresh strobe always wins the slot; losing an unissued byte is flagged
      pend_d     = dl_rise | (pend_q & ~issue_wr);
      pend_a_d   = dl_rise ? dl_addr : pend_a_q;
      pend_dat_d = dl_rise ? dl_data : pend_dat_q;
      ovr_d      = ovr_q | (dl_rise & pend_q & ~issue_wr);
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      a_d        = a_q;
      ds_d       = ds_q;
      d_d        = d_q;
      sel_d      = sel_q;
      last_d     = last_q;
      case (state_q)
         IDLE: begin
            if (pend_q) begin
               we_d    = 1'b1;
               a_d     = pend_a_q[AW:1];
               ds_d    = {pend_a_q[0], ~pend_a_q[0]};
               d_d     = {pend_dat_q, pend_dat_q};
               req_d   = ~req_q;
               state_d = WAIT;
            end else if (|pendr) begin
               we_d    = 1'b0;
               a_d     = full_addr[pick];
               ds_d    = 2'b11;
               sel_d   = pick;
               last_d  = pick;
               req_d   = ~req_q;
               state_d = WAIT;
            end
         end
         WAIT:    state_d = done ? IDLE : WAIT;
         DRAIN:   state_d = done ? IDLE : DRAIN;
         default: state_d = IDLE;
      endcase
   end
   // toggle parity must survive reset so the SDRAM side stays in step
   always_ff @(posedge clk_sys) begin
      if (reset_n) req_q <= req_d;
   end
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q    <= (mem_ack != req_q) ? DRAIN : IDLE;
         we_q       <= 1'b0;
         a_q        <= '0;
         ds_q       <= '0;
         d_q        <= '0;
         sel_q      <= RD_MAIN;
         last_q     <= RD_WAV;
         pend_q     <= 1'b0;
         pend_a_q   <= '0;
         pend_dat_q <= '0;
         ovr_q      <= 1'b0;
         dl_wr_q    <= 1'b0;
         dl_act_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         a_q        <= a_d;
         ds_q       <= ds_d;
         d_q        <= d_d;
         sel_q      <= sel_d;
         last_q     <= last_d;
         pend_q     <= pend_d;
         pend_a_q   <= pend_a_d;
         pend_dat_q <= pend_dat_d;
         ovr_q      <= ovr_d;
         dl_wr_q    <= dl_wr;
         dl_act_q   <= dl_active;
      end
   end
   for (genvar i = 0; i < 3; i++) begin : g_cache
      rom_word_cache #(.AW(AW)) u_cache (
         .clk_sys (clk_sys),
         .reset_n (reset_n),
         .clr     (act_rise),
         .ld      (ld_word && (sel_q == 2'(i))),
         .ld_tag  (a_q),
         .ld_data (mem_q),
         .addr    (full_addr[i]),
         .q       (word[i]),
         .ok      (ok[i])
      );
   end
   assign rd_q0   = word[RD_MAIN];
   assign rd_q1   = word[RD_SUB];
   assign rd_q2   = word[RD_WAV];
   assign rd_ok0  = ok[RD_MAIN];
   assign rd_ok1  = ok[RD_SUB];
   assign rd_ok2  = ok[RD_WAV];
   assign mem_req = req_q;
   assign mem_we  = we_q;
   assign mem_a   = a_q;
   assign mem_ds  = ds_q;
   assign mem_d   = d_q;
endmodule

// File: tb/tb_rom_fetch_sched.sv
// tb_rom_fetch_sched: directed scenario tests against a toggle-handshake SDRAM model
module tb_rom_fetch_sched;
   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0, dl_active = 1'b0, dl_wr = 1'b0;
   logic [23:0] dl_addr = '0;
   logic [7:0]  dl_data = '0;
   logic [22:0] rd_addr0 = '0, rd_addr1 = '0, rd_addr2 = '0;
   logic [15:0] rd_q0, rd_q1, rd_q2;
   logic        rd_ok0, rd_ok1, rd_ok2;
   logic        mem_req, mem_we;
   logic        mem_ack = 1'b0;
   logic [22:0] mem_a;
   logic [1:0]  mem_ds;
   logic [15:0] mem_d;
   logic [15:0] mem_q = '0;
   int          total = 0, bad = 0, ack_lat = 1, cnt = 0;
   logic        prev_req = 1'b0;
   logic [22:0] log_a [$];
   logic        log_we [$];
   logic [1:0]  log_ds [$];
   logic [15:0] log_d [$];

   always #5 clk_sys = ~clk_sys;

   rom_fetch_sched dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
      .dl_addr(dl_addr), .dl_data(dl_data), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
      .rd_addr2(rd_addr2), .rd_q0(rd_q0), .rd_q1(rd_q1), .rd_q2(rd_q2),
      .rd_ok0(rd_ok0), .rd_ok1(rd_ok1), .rd_ok2(rd_ok2), .mem_req(mem_req),
      .mem_ack(mem_ack), .mem_we(mem_we), .mem_a(mem_a), .mem_ds(mem_ds),
      .mem_d(mem_d), .mem_q(mem_q)
   );

   // SDRAM model: memory word at address a reads as a[15:0] ^ 16'hA55F
   always @(negedge clk_sys) begin
      if (mem_req !== prev_req) begin
         log_a.push_back(mem_a);
         log_we.push_back(mem_we);
         log_ds.push_back(mem_ds);
         log_d.push_back(mem_d);
      end
      prev_req = mem_req;
      if (mem_ack != mem_req) begin
         cnt++;
         if (cnt >= ack_lat) begin
            mem_q   = mem_a[15:0] ^ 16'hA55F;
            mem_ack = mem_req;
            cnt     = 0;
         end
      end else cnt = 0;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_sys);
         #2;
      end
   endtask

   task automatic do_reset;
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
   endtask

   task automatic wait_log(input int n);
      int k;
      k = 0;
      while (log_a.size() < n && k < 60) begin
         tick();
         k++;
      end
      total++;
      if (log_a.size() < n) begin
         bad++;
         $display("FAIL wait_log: requests seen %0d, required %0d", log_a.size(), n);
         $fatal(1, "request timeout");
      end
   endtask

   task automatic wait_ok(input logic [2:0] mask);
      int k;
      k = 0;
      while (({rd_ok2, rd_ok1, rd_ok0} & mask) != mask && k < 200) begin
         tick();
         k++;
      end
      total++;
      if (({rd_ok2, rd_ok1, rd_ok0} & mask) != mask) begin
         bad++;
         $display("FAIL wait_ok: rd_ok=%b, required mask %b", {rd_ok2, rd_ok1, rd_ok0}, mask);
         $fatal(1, "rd_ok timeout");
      end
   endtask

   task automatic test_reset;
      int n0;
      rd_addr0 = 23'd5;
      ack_lat  = 1;
      reset_n  = 1'b0;
      tick(3);
      total++;
      if ({rd_ok2, rd_ok1, rd_ok0} !== 3'b000) begin bad++; $display("FAIL reset_ok: got %b want 000", {rd_ok2, rd_ok1, rd_ok0}); end
      total++;
      if ({rd_q0, rd_q1, rd_q2} !== 48'h0) begin bad++; $display("FAIL reset_q: got %h want 0", {rd_q0, rd_q1, rd_q2}); end
      total++;
      if ({mem_we, mem_a, mem_ds} !== 26'h0) begin bad++; $display("FAIL reset_mem: got we=%b a=%h ds=%b want 0", mem_we, mem_a, mem_ds); end
      reset_n = 1'b1;
      n0 = log_a.size();
      wait_log(n0 + 1);
      total++;
      if ({log_we[n0], log_a[n0], log_ds[n0]} !== {1'b0, 23'd5, 2'b11}) begin
         bad++; $display("FAIL first_read: got we=%b a=%h ds=%b want 0/5/11", log_we[n0], log_a[n0], log_ds[n0]);
      end
      wait_ok(3'b001);
      total++;
      if (rd_q0 !== 16'hA55A) begin bad++; $display("FAIL first_data: got %h want a55a", rd_q0); end
      wait_ok(3'b111);
      n0 = log_a.size();
      tick(6);
      total++;
      if (log_a.size() != n0 || rd_ok0 !== 1'b1) begin
         bad++; $display("FAIL hit_no_fetch: requests %0d ok0=%b want %0d/1", log_a.size(), rd_ok0, n0);
      end
   endtask

   task automatic test_round_robin;
      int n0;
      rd_addr0 = 23'd5; rd_addr1 = 23'd5; rd_addr2 = 23'd5;
      ack_lat  = 2;
      do_reset();
      n0 = log_a.size();
      wait_log(n0 + 3);
      total++;
      if ({log_a[n0], log_a[n0+1], log_a[n0+2]} !== {23'h000005, 23'h007005, 23'h008005}) begin
         bad++; $display("FAIL rr_order: got %h %h %h want 5 7005 8005", log_a[n0], log_a[n0+1], log_a[n0+2]);
      end
      wait_ok(3'b111);
      total++;
      if ({rd_q0, rd_q1, rd_q2} !== {16'hA55A, 16'hD55A, 16'h255A}) begin
         bad++; $display("FAIL rr_data: got %h %h %h want a55a d55a 255a", rd_q0, rd_q1, rd_q2);
      end
   endtask

   task automatic test_download;
      int n0;
      ack_lat   = 1;
      dl_active = 1'b1;
      do_reset();
      n0 = log_a.size();
      tick();
      dl_addr = 24'h000003; dl_data = 8'h3C; dl_wr = 1'b1;
      tick();
      dl_wr = 1'b0;
      wait_log(n0 + 1);
      total++;
      if ({log_we[n0], log_a[n0], log_ds[n0], log_d[n0]} !== {1'b1, 23'd1, 2'b10, 16'h3C3C}) begin
         bad++; $display("FAIL dl_write: got we=%b a=%h ds=%b d=%h want 1/1/10/3c3c", log_we[n0], log_a[n0], log_ds[n0], log_d[n0]);
      end
      tick(8);
      total++;
      if (log_a.size() != n0 + 1 || rd_ok0 !== 1'b0) begin
         bad++; $display("FAIL dl_blocks: requests %0d ok0=%b want %0d/0", log_a.size(), rd_ok0, n0 + 1);
      end
      dl_active = 1'b0;
   endtask

   task automatic test_back_to_back;
      int n0, n1;
      rd_addr0 = 23'd5; rd_addr1 = 23'd5; rd_addr2 = 23'd5;
      ack_lat  = 4;
      do_reset();
      n0 = log_a.size();
      tick();
      dl_addr = 24'h000010; dl_data = 8'h77; dl_wr = 1'b1;
      tick();
      dl_wr = 1'b0;
      wait_log(n0 + 3);
      total++;
      if ({log_we[n0+1], log_a[n0+1], log_ds[n0+1], log_d[n0+1]} !== {1'b1, 23'd8, 2'b01, 16'h7777}) begin
         bad++; $display("FAIL wr_first: got we=%b a=%h ds=%b d=%h want 1/8/01/7777", log_we[n0+1], log_a[n0+1], log_ds[n0+1], log_d[n0+1]);
      end
      total++;
      if ({log_we[n0+2], log_a[n0+2]} !== {1'b0, 23'h007005}) begin
         bad++; $display("FAIL rd_after_wr: got we=%b a=%h want 0/7005", log_we[n0+2], log_a[n0+2]);
      end
      wait_ok(3'b111);
      dl_active = 1'b1;
      tick();
      total++;
      if ({rd_ok2, rd_ok1, rd_ok0} !== 3'b000) begin bad++; $display("FAIL dl_flush: got %b want 000", {rd_ok2, rd_ok1, rd_ok0}); end
      rd_addr0 = 23'd9;
      n1 = log_a.size();
      tick(10);
      total++;
      if (log_a.size() != n1) begin bad++; $display("FAIL dl_reads_blocked: requests %0d want %0d", log_a.size(), n1); end
      dl_active = 1'b0;
      wait_log(n1 + 1);
      total++;
      if (log_a[n1] !== 23'd9) begin bad++; $display("FAIL resume_addr: got %h want 9", log_a[n1]); end
      wait_ok(3'b111);
      total++;
      if (rd_q0 !== 16'hA556) begin bad++; $display("FAIL resume_data: got %h want a556", rd_q0); end
   endtask

   task automatic test_reset_drain;
      int n0;
      ack_lat  = 6;
      rd_addr0 = 23'd11;
      n0 = log_a.size();
      wait_log(n0 + 1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      total++;
      if ({rd_ok0, rd_q0} !== 17'h0) begin bad++; $display("FAIL drain_reset: got ok=%b q=%h want 0/0", rd_ok0, rd_q0); end
      wait_log(n0 + 2);
      total++;
      if (rd_q0 !== 16'h0 || rd_ok0 !== 1'b0) begin bad++; $display("FAIL drain_discard: got ok=%b q=%h want 0/0", rd_ok0, rd_q0); end
      total++;
      if (log_a[n0+1] !== 23'd11) begin bad++; $display("FAIL drain_refetch: got %h want b", log_a[n0+1]); end
      wait_ok(3'b001);
      total++;
      if (rd_q0 !== 16'hA554) begin bad++; $display("FAIL drain_data: got %h want a554", rd_q0); end
      wait_ok(3'b111);
   endtask

   task automatic test_addr_change;
      int n0;
      ack_lat  = 3;
      rd_addr0 = 23'd20;
      n0 = log_a.size();
      wait_log(n0 + 1);
      rd_addr0 = 23'd21;
      wait_log(n0 + 2);
      total++;
      if ({log_a[n0], log_a[n0+1]} !== {23'd20, 23'd21}) begin
         bad++; $display("FAIL chg_fetches: got %h %h want 14 15", log_a[n0], log_a[n0+1]);
      end
      total++;
      if (rd_ok0 !== 1'b0 || rd_q0 !== 16'hA54B) begin
         bad++; $display("FAIL chg_old_tag: got ok=%b q=%h want 0/a54b", rd_ok0, rd_q0);
      end
      wait_ok(3'b001);
      total++;
      if (rd_q0 !== 16'hA54A) begin bad++; $display("FAIL chg_data: got %h want a54a", rd_q0); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_download();
      test_back_to_back();
      test_reset_drain();
      test_addr_change();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
